// File: rtl/vbuf_gear.sv
// Byte FIFO feeding a bit gearbox that unpacks bytes LSB-first into {R,G,B} pixels for a DAC.
// Define VBUF_UNDERRUN_HOLD_EN to hold the previous pixel on underrun instead of forcing black.
module vbuf_gear #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CDEPTH = 2,
  parameter int unsigned AWIDTH = 4
) (
  input  logic                PixelClk,
  input  logic                Reset,
  input  logic                Flush,
  input  logic [DWIDTH-1:0]   ByteIn,
  input  logic                ByteValid,
  output logic                ByteReady,
  input  logic                PixelEn,
  input  logic                Blank,
  output logic [3*CDEPTH-1:0] VideoOut,
  output logic [AWIDTH:0]     Level,
  output logic                Underrun
);

  localparam int unsigned PWIDTH = 3 * CDEPTH;
  localparam int unsigned GW     = DWIDTH + PWIDTH;
  localparam int unsigned DEPTH  = 2 ** AWIDTH;
  localparam int unsigned CW     = $clog2(GW + 1);
  localparam int unsigned EW     = CW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d, level, level_d;
  logic              ready_q;
  logic [GW-1:0]     acc_q, acc_d, acc_shift;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_rem;
  logic [PWIDTH-1:0] video_q, video_d;
  logic              underrun_q, underrun_d;
  logic              wr_en, rd_en, empty, consume;

  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign wr_en = ByteValid && ready_q && !Flush;

  always_comb begin
    consume   = PixelEn && !Blank && (cnt_q >= CW'(PWIDTH));
    cnt_rem   = consume ? cnt_q - CW'(PWIDTH) : cnt_q;
    acc_shift = consume ? (acc_q >> PWIDTH) : acc_q;
    // Load only when the whole byte fits above the bits still held after this cycle's pixel
    rd_en     = !empty && (({1'b0, cnt_rem} + EW'(DWIDTH)) <= EW'(GW));

    acc_d      = acc_shift;
    cnt_d      = cnt_rem;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    video_d    = video_q;
    underrun_d = underrun_q;

    if (rd_en) begin
      // Bits of acc above cnt are always zero, so OR-ing in the new byte is safe
      acc_d  = acc_shift | (GW'(mem[rptr_q[AWIDTH-1:0]]) << cnt_rem);
      cnt_d  = cnt_rem + CW'(DWIDTH);
      rptr_d = rptr_q + (AWIDTH + 1)'(1);
    end
    if (wr_en) begin
      wptr_d = wptr_q + (AWIDTH + 1)'(1);
    end

    if (PixelEn) begin
      if (Blank) begin
        video_d = '0;
      end else if (consume) begin
        video_d = acc_q[PWIDTH-1:0];
      end else begin
        underrun_d = 1'b1;
`ifdef VBUF_UNDERRUN_HOLD_EN
        video_d = video_q;
`else
        video_d = '0;
`endif
      end
    end

    if (Flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      acc_d      = '0;
      cnt_d      = '0;
      video_d    = '0;
      underrun_d = 1'b0;
    end

    level_d = wptr_d - rptr_d;
  end

  always_ff @(posedge PixelClk) begin
    if (wr_en) begin
      mem[wptr_q[AWIDTH-1:0]] <= ByteIn;
    end
  end

  always_ff @(posedge PixelClk or posedge Reset) begin
    if (Reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ready_q    <= 1'b1;
      acc_q      <= '0;
      cnt_q      <= '0;
      video_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ready_q    <= (level_d != (AWIDTH + 1)'(DEPTH));
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      video_q    <= video_d;
      underrun_q <= underrun_d;
    end
  end

  assign ByteReady = ready_q;
  assign VideoOut  = video_q;
  assign Level     = level;
  assign Underrun  = underrun_q;

endmodule

// File: tb/tb_vbuf_gear.sv
// Directed bench for vbuf_gear with default parameters (8-bit bytes, 6-bit pixels, 16-deep FIFO).
// Build with VBUF_UNDERRUN_HOLD_EN defined to check the hold-on-underrun variant.
module tb_vbuf_gear;

`ifdef VBUF_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] din;
  logic       valid;
  logic       ready;
  logic       pe;
  logic       blank;
  logic [5:0] video;
  logic [4:0] level;
  logic       underrun;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       pe;
    logic       blank;
    logic       valid;
    logic [7:0] din;
    logic       flush;
    logic [5:0] vid;
    logic [4:0] lvl;
    logic       rdy;
    logic       ur;
  } vec_t;

  vec_t vecs[$];

  vbuf_gear dut (
    .PixelClk (clk),
    .Reset    (rst),
    .Flush    (flush),
    .ByteIn   (din),
    .ByteValid(valid),
    .ByteReady(ready),
    .PixelEn  (pe),
    .Blank    (blank),
    .VideoOut (video),
    .Level    (level),
    .Underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and return 1 time unit after the rising edge
  task automatic step(input logic p, input logic b, input logic v, input logic [7:0] d,
                      input logic f);
    pe = p; blank = b; valid = v; din = d; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic p, input logic b, input logic v, input logic [7:0] d,
                     input logic f, input logic [5:0] ev, input logic [4:0] el,
                     input logic er, input logic eu);
    vec_t t;
    t.pe = p; t.blank = b; t.valid = v; t.din = d; t.flush = f;
    t.vid = ev; t.lvl = el; t.rdy = er; t.ur = eu;
    vecs.push_back(t);
  endtask

  initial begin
    logic [5:0] uv;
    int accepted;
    uv = HOLD ? 6'h2A : 6'h00;

    //  pe blank valid din  flush  video lvl rdy ur
    add(0, 0, 1, 8'hC3, 0, 6'h00, 1, 1, 0);
    add(0, 0, 1, 8'h55, 0, 6'h00, 1, 1, 0);
    add(0, 0, 1, 8'hAA, 0, 6'h00, 2, 1, 0);
    add(0, 0, 0, 8'h00, 0, 6'h00, 2, 1, 0);
    add(1, 0, 0, 8'h00, 0, 6'h03, 1, 1, 0);
    add(1, 0, 0, 8'h00, 0, 6'h17, 0, 1, 0);
    add(1, 0, 0, 8'h00, 0, 6'h25, 0, 1, 0);
    add(1, 0, 0, 8'h00, 0, 6'h2A, 0, 1, 0);
    add(0, 0, 0, 8'h00, 0, 6'h2A, 0, 1, 0);
    add(1, 0, 0, 8'h00, 0, uv,    0, 1, 1);  // underrun
    add(0, 0, 1, 8'h3F, 0, uv,    1, 1, 1);  // sticky after new data
    add(0, 0, 0, 8'h00, 0, uv,    0, 1, 1);
    add(1, 0, 0, 8'h00, 0, 6'h3F, 0, 1, 1);
    add(0, 0, 1, 8'h12, 1, 6'h00, 0, 1, 0);  // flush drops same-cycle byte
    add(0, 0, 0, 8'h00, 0, 6'h00, 0, 1, 0);
    add(1, 0, 0, 8'h00, 0, 6'h00, 0, 1, 1);
    add(0, 0, 0, 8'h00, 1, 6'h00, 0, 1, 0);
    add(0, 0, 1, 8'hC3, 0, 6'h00, 1, 1, 0);
    add(0, 0, 1, 8'h55, 0, 6'h00, 1, 1, 0);
    add(1, 1, 0, 8'h00, 0, 6'h00, 1, 1, 0);  // blanking: nothing consumed
    add(1, 1, 0, 8'h00, 0, 6'h00, 1, 1, 0);
    add(1, 0, 0, 8'h00, 0, 6'h03, 0, 1, 0);
    add(1, 1, 0, 8'h00, 0, 6'h00, 0, 1, 0);
    add(1, 0, 0, 8'h00, 0, 6'h17, 0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 6'h00, 0, 1, 0);

    rst = 1'b1; flush = 1'b0; din = '0; valid = 1'b0; pe = 1'b0; blank = 1'b0;
    #12;
    check("reset video", video, 0);
    check("reset level", level, 0);
    check("reset underrun", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready after reset", ready, 1);

    foreach (vecs[i]) begin
      step(vecs[i].pe, vecs[i].blank, vecs[i].valid, vecs[i].din, vecs[i].flush);
      check($sformatf("vec%0d video", i), video, vecs[i].vid);
      check($sformatf("vec%0d level", i), level, vecs[i].lvl);
      check($sformatf("vec%0d ready", i), ready, vecs[i].rdy);
      check($sformatf("vec%0d underrun", i), underrun, vecs[i].ur);
    end

    // Fill: 16 bytes in the FIFO plus one in the gearbox
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready) accepted++;
      step(0, 0, 1, 8'(i + 1), 0);
    end
    check("fill accepted", accepted, 17);
    check("fill level", level, 16);
    check("fill ready", ready, 0);
    // Read while full with a byte offered: no same-cycle accept
    step(1, 0, 1, 8'hEE, 0);
    check("full read level", level, 15);
    check("full read ready", ready, 1);
    check("full read video", video, 6'h01);
    step(0, 0, 1, 8'hEE, 0);
    check("refill level", level, 16);
    check("refill ready", ready, 0);

    // Flush while full with a byte offered
    step(0, 0, 1, 8'h99, 1);
    check("flush level", level, 0);
    check("flush video", video, 0);
    check("flush ready", ready, 1);
    step(0, 0, 0, 8'h00, 0);
    check("post flush level", level, 0);
    step(1, 0, 0, 8'h00, 0);
    check("post flush underrun", underrun, 1);

    // Mid-stream async reset with five bytes queued
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'hFF, 0);
    step(1, 0, 0, 8'h00, 0);
    check("pre reset level", level, 5);
    check("pre reset video", video, 6'h3F);
    check("pre reset underrun", underrun, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset video", video, 0);
    check("async reset level", level, 0);
    check("async reset underrun", underrun, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(0, 0, 0, 8'h00, 0);
    check("release ready", ready, 1);
    check("release level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vbuf_gear.md
Name: vbuf_gear

Overview:
Parametrised single-clock video buffer and successor to the fixed 8-bit-to-6-bit pixel path. It accepts packed pixel bytes through a valid/ready handshake into a byte FIFO. A generic bit gearbox unpacks each byte into PWIDTH-bit pixels, LSB first. It drives the DAC pins on pixel strobes, forces black during blanking and flags underrun.

Parameters:
DWIDTH, 8, input byte width in bits
CDEPTH, 2, bits per colour channel; PWIDTH = 3*CDEPTH (localparam)
AWIDTH, 4, FIFO address width; FIFO depth DEPTH = 2**AWIDTH bytes

Ports:
PixelClk  in  1  sole clock, rising edge
Reset  in  1  asynchronous, active-high reset
Flush  in  1  synchronous clear of FIFO, gearbox and flags (frame start)
ByteIn  in  DWIDTH  packed pixel data
ByteValid  in  1  ByteIn valid
ByteReady  out  1  buffer can accept a byte
PixelEn  in  1  pixel-advance strobe (one per pixel period)
Blank  in  1  blanking interval
VideoOut  out  PWIDTH  registered RGB pixel, {R,G,B} at CDEPTH bits each
Level  out  AWIDTH+1  FIFO occupancy in bytes
Underrun  out  1  sticky: pixel requested with insufficient data

Behaviour:
- Reset (async): FIFO pointers 0, gearbox count 0, VideoOut=0, Level=0, Underrun=0. ByteReady=1 once Reset is released.
- Write: a byte is accepted when ByteValid && ByteReady. ByteReady = !full, registered from the occupancy. When full, a same-cycle gearbox read does not raise ByteReady.
- No bypass: a byte written in cycle t is visible to the gearbox in cycle t+1.
- Gearbox: accumulator Acc of GW = DWIDTH+PWIDTH bits, count Cnt in 0..GW.
- Each cycle: consume = PixelEn && !Blank && Cnt>=PWIDTH. C' = Cnt - (consume ? PWIDTH : 0).
- Load a byte from the FIFO when FIFO non-empty && C'+DWIDTH <= GW. The byte is placed at Acc bit position C' and Cnt becomes C'+DWIDTH. Acc shifts right by PWIDTH on consume.
- Output, updated in the cycle after the PixelEn strobe (1-cycle latency):
  - PixelEn && Blank: VideoOut <= 0. No data consumed.
  - consume: VideoOut <= Acc[PWIDTH-1:0].
  - PixelEn && !Blank && Cnt<PWIDTH (underrun): VideoOut <= 0, Underrun <= 1. Partial bits are kept.
  - No PixelEn: VideoOut holds its value.
- Underrun is cleared only by Reset or Flush.
- Flush has priority over everything. It empties the FIFO, sets Cnt=0, VideoOut=0 and Underrun=0, and discards any write in the same cycle. ByteReady=1 in the next cycle.
- Level counts FIFO entries only, not gearbox bits. Pointers wrap modulo DEPTH; full/empty are distinguished by the extra pointer MSB.
- Simultaneous write and gearbox read: Level is unchanged.
- Constraint: DWIDTH >= 1, PWIDTH >= 1. Any ratio is legal; residual bits carry over into the next byte.

Optional Feature:
VBUF_UNDERRUN_HOLD_EN
- Defined: on underrun, VideoOut holds the previous pixel instead of going to 0. Underrun is still set.
- Undefined: on underrun, VideoOut is forced to 0.
- Blanking forces 0 in both cases.

Test Plan:
1. Reset pulse mid-stream with FIFO holding 5 bytes -> immediately VideoOut=0, Level=0, Underrun=0; ByteReady=1 after release.
2. Defaults. Write 0xC3, 0x55, 0xAA, then 4 PixelEn strobes with Blank=0 -> VideoOut sequence 0x03, 0x17, 0x25, 0x2A, each 1 cycle after its strobe; Underrun=0.
3. Defaults. Write 20 bytes back-to-back with PixelEn=0 -> exactly 17 accepted (16 in FIFO, 1 in gearbox); ByteReady=0; Level=16.
4. Blank=1 with 4 PixelEn strobes and data present -> VideoOut=0, Level and Cnt unchanged. After Blank=0, the next pixel is the first unconsumed one.
5. Empty buffer, PixelEn with Blank=0 -> VideoOut=0 (previous value with VBUF_UNDERRUN_HOLD_EN), Underrun=1. Underrun stays 1 after new data arrives and clears on Flush.
6. Flush asserted with ByteValid=1 and FIFO non-empty -> next cycle Level=0, VideoOut=0, the same-cycle byte is discarded, ByteReady=1.
